// File: rtl/if_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   pf_state_e  : fetch FSM states (idle, request outstanding, discard in-flight)
//   pf_entry_t  : one queue entry, {instruction word, its PC}
//   NOP_INSTR   : value presented on inst while the queue is empty
//   PC_STEP     : sequential fetch increment in bytes
package if_prefetch_queue_pkg;

    typedef enum logic [1:0] {
        PF_IDLE    = 2'd0,
        PF_REQ     = 2'd1,
        PF_DISCARD = 2'd2
    } pf_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } pf_entry_t;

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// prefetch_fifo: DEPTH-entry circular buffer of {instr, pc} pairs.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   push_i, push_*_i       write one entry at the tail
//   pop_i                  retire the head entry
//   clear_i                drop all entries (takes priority over push/pop)
//   count_o                number of valid entries (0..DEPTH)
//   head_instr_o/head_pc_o head entry contents (undefined when count_o == 0)
module prefetch_fifo
    import if_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [31:0]             push_instr_i,
    input  logic [31:0]             push_pc_i,
    input  logic                    pop_i,
    input  logic                    clear_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [31:0]             head_instr_o,
    output logic [31:0]             head_pc_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    pf_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   wr_q;
    logic [CW-1:0]   cnt_q;
    logic            do_push;
    logic            do_pop;
    pf_entry_t       head;

    // Guard against pop-when-empty and push-when-full; a same-cycle pop
    // frees the slot a full-queue push needs.
    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != FULL) || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
            else if (!do_push && do_pop) cnt_q <= cnt_q - CW'(1);
        end
    end

    // Storage needs no reset: entries are only observed when counted valid.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_q] <= '{instr: push_instr_i, pc: push_pc_i};
        end
    end

    assign head         = mem_q[rd_q];
    assign head_instr_o = head.instr;
    assign head_pc_o    = head.pc;
    assign count_o      = cnt_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: sequential instruction prefetcher feeding the IF stage.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   redirect, redirect_pc      branch/jump taken: flush and refetch from redirect_pc
//   hold                       IF stalled; head entry is not consumed
//   mem_req, mem_addr          fetch request (address stable while mem_req=1)
//   mem_ack, mem_rdata         request completion and returned word
//   inst_valid, inst           head entry valid / instruction (NOP when empty)
//   inst_pc, inst_pc4          PC of head instruction and PC+4
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        hold,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    pf_state_e      state_q;
    logic [31:0]    fetch_pc_q;
    logic [31:0]    mem_addr_q;
    logic           mem_req_q;

    logic [CW-1:0]  count;
    logic [CW-1:0]  count_post;
    logic [31:0]    head_instr;
    logic [31:0]    head_pc;
    logic           push;
    logic           pop;
    logic           room;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && !hold && !redirect;
    assign push       = (state_q == PF_REQ) && mem_ack && !redirect;

    // Occupancy after this edge's push/pop; decides whether to keep fetching.
    always_comb begin
        count_post = count;
        if (push && !pop)      count_post = count + CW'(1);
        else if (!push && pop) count_post = count - CW'(1);
    end

    assign room = (count_post < FULL);

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .push_i       (push),
        .push_instr_i (mem_rdata),
        .push_pc_i    (mem_addr_q),
        .pop_i        (pop),
        .clear_i      (redirect),
        .count_o      (count),
        .head_instr_o (head_instr),
        .head_pc_o    (head_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PF_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
        end else if (redirect) begin
            fetch_pc_q <= redirect_pc;
            case (state_q)
                PF_IDLE: begin
                    state_q    <= PF_REQ;
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= redirect_pc;
                end
                PF_REQ: begin
                    // An acked request is complete and can be dropped now;
                    // otherwise it must be allowed to finish before refetching.
                    if (mem_ack) mem_addr_q <= redirect_pc;
                    else         state_q    <= PF_DISCARD;
                end
                PF_DISCARD: begin
                    // Outstanding request is still owed an ack; only the
                    // refetch target moves.
                end
                default: begin
                    state_q   <= PF_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end else begin
            case (state_q)
                PF_IDLE: begin
                    if (room) begin
                        state_q    <= PF_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                PF_REQ: begin
                    if (mem_ack) begin
                        fetch_pc_q <= fetch_pc_q + PC_STEP;
                        if (room) begin
                            mem_addr_q <= fetch_pc_q + PC_STEP;
                        end else begin
                            state_q   <= PF_IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                PF_DISCARD: begin
                    if (mem_ack) begin
                        state_q    <= PF_REQ;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                default: begin
                    state_q   <= PF_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign inst     = inst_valid ? head_instr : NOP_INSTR;
    assign inst_pc  = inst_valid ? head_pc : '0;
    assign inst_pc4 = inst_pc + PC_STEP;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: vector table, directed
// redirect/reset sequences and a randomized run against a queue model.
module tb_if_prefetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        hold = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(logic [31:0] a);
        return (a ^ 32'h5A5A_A5A5) + {a[7:0], 24'h13_57_9B};
    endfunction

    assign mem_rdata = mdata(mem_addr);

    if_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .hold        (hold),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_pc4    (inst_pc4)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    bit          m_busy;
    bit          m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_next;

    task automatic model_reset();
        mq.delete();
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_addr = '0;
        m_next = RESET_PC;
    endtask

    task automatic model_step(bit h, bit a, bit r, logic [31:0] rp);
        bit pop;
        pop = (mq.size() != 0) && !h && !r;
        if (r) begin
            mq.delete();
            m_next = rp;
            if (!m_busy) begin
                m_busy = 1'b1;
                m_addr = rp;
            end else if (!m_drop) begin
                if (a) m_addr = rp;
                else   m_drop = 1'b1;
            end
        end else begin
            if (pop) mq.delete(0);
            if (m_busy && a) begin
                if (m_drop) begin
                    m_drop = 1'b0;
                    m_addr = m_next;
                end else begin
                    mq.push_back('{pc: m_addr, ins: mdata(m_addr)});
                    m_next = m_addr + 32'd4;
                    if (mq.size() < DEPTH) m_addr = m_next;
                    else                   m_busy = 1'b0;
                end
            end else if (!m_busy && mq.size() < DEPTH) begin
                m_busy = 1'b1;
                m_addr = m_next;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step();
        logic [31:0] e_ins;
        logic [31:0] e_pc;
        e_ins = (mq.size() != 0) ? mq[0].ins : 32'h0;
        e_pc  = (mq.size() != 0) ? mq[0].pc  : 32'h0;
        chk("model_req",   32'(mem_req),    32'(m_busy));
        chk("model_addr",  mem_addr,        m_addr);
        chk("model_valid", 32'(inst_valid), 32'(mq.size() != 0));
        chk("model_inst",  inst,            e_ins);
        chk("model_pc",    inst_pc,         e_pc);
        chk("model_pc4",   inst_pc4,        e_pc + 32'd4);
        model_step(hold, mem_ack, redirect, redirect_pc);
        @(posedge clk);
        #1;
    endtask

    // Asserts reset away from a clock edge, confirms outputs clear
    // immediately, and releases on the following falling edge.
    task automatic do_reset();
        rst_n       = 1'b0;
        hold        = 1'b0;
        mem_ack     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        model_reset();
        #2;
        chk("rst_req",   32'(mem_req),    32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst",  inst,            32'h0);
        chk("rst_pc4",   inst_pc4,        32'h4);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rst;
        bit          h;
        bit          a;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    task automatic tv(bit rst, bit h, bit a, bit e_req, logic [31:0] e_addr,
                      bit e_valid, logic [31:0] e_pc);
        tbl.push_back('{rst: rst, h: h, a: a, e_req: e_req, e_addr: e_addr,
                        e_valid: e_valid, e_pc: e_pc});
    endtask

    initial begin
        // Streaming with single-cycle ack: one instruction per cycle.
        tv(1, 0, 1, 0, 32'h00, 0, 32'h00);
        tv(0, 0, 1, 1, 32'h00, 0, 32'h00);
        tv(0, 0, 1, 1, 32'h04, 1, 32'h00);
        tv(0, 0, 1, 1, 32'h08, 1, 32'h04);
        tv(0, 0, 1, 1, 32'h0C, 1, 32'h08);
        tv(0, 0, 1, 1, 32'h10, 1, 32'h0C);
        // Stall from reset for 10 cycles: fill to DEPTH, then stop requesting.
        tv(1, 1, 1, 0, 32'h00, 0, 32'h00);
        tv(0, 1, 1, 1, 32'h00, 0, 32'h00);
        tv(0, 1, 1, 1, 32'h04, 1, 32'h00);
        tv(0, 1, 1, 1, 32'h08, 1, 32'h00);
        tv(0, 1, 1, 1, 32'h0C, 1, 32'h00);
        for (int i = 0; i < 5; i++) tv(0, 1, 1, 0, 32'h0C, 1, 32'h00);
        tv(0, 0, 1, 0, 32'h0C, 1, 32'h00);
        tv(0, 0, 1, 1, 32'h10, 1, 32'h04);
        tv(0, 0, 1, 1, 32'h14, 1, 32'h08);
        tv(0, 0, 1, 1, 32'h18, 1, 32'h0C);
        tv(0, 0, 1, 1, 32'h1C, 1, 32'h10);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            hold     = tbl[i].h;
            mem_ack  = tbl[i].a;
            redirect = 1'b0;
            chk("tv_req",   32'(mem_req),    32'(tbl[i].e_req));
            chk("tv_addr",  mem_addr,        tbl[i].e_addr);
            chk("tv_valid", 32'(inst_valid), 32'(tbl[i].e_valid));
            chk("tv_pc",    inst_pc,         tbl[i].e_pc);
            chk("tv_pc4",   inst_pc4,        tbl[i].e_pc + 32'd4);
            chk("tv_inst",  inst, tbl[i].e_valid ? mdata(tbl[i].e_pc) : 32'h0);
            step();
        end

        // ---------------- delayed ack (3 wait cycles) ----------------
        begin
            int          w;
            bit          p_req;
            bit          p_ack;
            logic [31:0] p_addr;
            logic [31:0] exp_pc;
            do_reset();
            w = 0; p_req = 0; p_ack = 0; p_addr = '0; exp_pc = RESET_PC;
            for (int c = 0; c < 40; c++) begin
                mem_ack = mem_req && (w == 3);
                if (p_req && !p_ack && mem_req) chk("slow_addr_stable", mem_addr, p_addr);
                if (inst_valid) begin
                    chk("slow_pc_seq", inst_pc, exp_pc);
                    exp_pc = exp_pc + 32'd4;
                end
                p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr;
                if (mem_req) w = mem_ack ? 0 : w + 1;
                step();
            end
            chk("slow_words", exp_pc, RESET_PC + 32'h24);
        end

        // ---------------- redirect sequences ----------------
        do_reset();
        hold = 1'b1; mem_ack = 1'b1;
        step(); step(); step();
        chk("rd40_pre_valid", 32'(inst_valid), 32'h1);
        chk("rd40_pre_addr",  mem_addr,        32'h08);
        mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        chk("rd40_flush_valid", 32'(inst_valid), 32'h0);
        chk("rd40_hold_req",    32'(mem_req),    32'h1);
        chk("rd40_hold_addr",   mem_addr,        32'h08);
        step();
        mem_ack = 1'b1;
        chk("rd40_disc_addr", mem_addr, 32'h08);
        step();
        hold = 1'b0;
        chk("rd40_new_addr", mem_addr,        32'h40);
        chk("rd40_dropped",  32'(inst_valid), 32'h0);
        step();
        chk("rd40_first_valid", 32'(inst_valid), 32'h1);
        chk("rd40_first_pc",    inst_pc,         32'h40);
        // Redirect together with an ack and a would-be pop.
        redirect = 1'b1; redirect_pc = 32'h80; mem_ack = 1'b1;
        step();
        redirect = 1'b0; mem_ack = 1'b0;
        chk("rd80_empty", 32'(inst_valid), 32'h0);
        chk("rd80_req",   32'(mem_req),    32'h1);
        chk("rd80_addr",  mem_addr,        32'h80);
        step();
        mem_ack = 1'b1;
        step();
        chk("rd80_first_pc", inst_pc, 32'h80);
        // Two redirects while an old request is still outstanding.
        mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_pc = 32'h200;
        chk("rd2_addr_a", mem_addr, 32'h84);
        step();
        redirect = 1'b0;
        chk("rd2_addr_b", mem_addr, 32'h84);
        step();
        mem_ack = 1'b1;
        chk("rd2_not100", 32'(mem_addr == 32'h100), 32'h0);
        step();
        chk("rd2_req",  32'(mem_req), 32'h1);
        chk("rd2_addr", mem_addr,     32'h200);
        step();
        chk("rd2_first_pc", inst_pc, 32'h200);

        // ---------------- reset in the middle of a request ----------------
        mem_ack = 1'b0;
        chk("midrst_pre_req", 32'(mem_req), 32'h1);
        #1;
        do_reset();
        chk("midrst_c0_req", 32'(mem_req), 32'h0);
        step();
        chk("midrst_c1_req",  32'(mem_req), 32'h1);
        chk("midrst_c1_addr", mem_addr,     RESET_PC);
        step();

        // ---------------- randomized run ----------------
        for (int i = 0; i < 3000; i++) begin
            if (((i / 300) % 2) == 1) hold = ($urandom_range(0, 9) != 0);
            else                      hold = ($urandom_range(0, 9) < 3);
            mem_ack     = mem_req && ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4
                                                      : ($urandom & 32'hFFFF_FFFC);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
